// File: rtl/data_path_pkg.sv
// Shared constants for the data path and its control logic: word/address widths,
// function-select opcodes and the power-up memory image.
package data_path_pkg;

   localparam int WORD_W    = 16;
   localparam int ADDR_W    = 6;
   localparam int NUM_REGS  = 16;
   localparam int MEM_DEPTH = 64;

   typedef logic [WORD_W-1:0] word_t;
   typedef word_t mem_image_t [MEM_DEPTH];

   typedef enum logic [3:0] {
      FS_PASS_A   = 4'b0000,
      FS_INC      = 4'b0001,
      FS_ADD      = 4'b0010,
      FS_ADD_INC  = 4'b0011,
      FS_ADD_NOTB = 4'b0100,
      FS_SUB      = 4'b0101,
      FS_DEC      = 4'b0110,
      FS_PASS_A2  = 4'b0111,
      FS_AND      = 4'b1000,
      FS_OR       = 4'b1001,
      FS_XOR      = 4'b1010,
      FS_NOT_A    = 4'b1011,
      FS_PASS_B   = 4'b1100,
      FS_SHR      = 4'b1101,
      FS_SHL      = 4'b1110,
      FS_ZERO     = 4'b1111
   } fs_e;

   // Word i of the power-up image is {2'b10, i, 8'h5A}, so every location is distinct.
   function automatic mem_image_t mem_image();
      mem_image_t img;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         img[i] = {2'b10, ADDR_W'(i), 8'h5A};
      end
      return img;
   endfunction

endpackage

// File: rtl/data_path_if.sv
// Control-path <-> data-path signal bundle; the control path is the master.
interface data_path_if;
   import data_path_pkg::*;

   logic [3:0]        DR;
   logic [3:0]        SA;
   logic [3:0]        SB;
   logic [3:0]        FS;
   logic              MB;
   logic              MD;
   logic              MM;
   logic              MW;
   logic              RW;
   logic [ADDR_W-1:0] PC;
   word_t             InstructIn;
   logic [ADDR_W-1:0] BusA;
   logic              Z;

   modport master (
      output DR, SA, SB, FS, MB, MD, MM, MW, RW, PC,
      input  InstructIn, BusA, Z
   );

   modport slave (
      input  DR, SA, SB, FS, MB, MD, MM, MW, RW, PC,
      output InstructIn, BusA, Z
   );
endinterface

// File: rtl/data_path_function_unit.sv
// Combinational ALU/shifter of the data path; carries are discarded (modulo 2^16).
module function_unit
   import data_path_pkg::*;
(
   input  word_t      A,
   input  word_t      B,
   input  logic [3:0] FS,
   output word_t      F,
   output logic       Z
);

   word_t f_s;

   // Operation select
   always_comb begin
      f_s = 16'h0000;
      case (fs_e'(FS))
         FS_PASS_A:   f_s = A;
         FS_INC:      f_s = A + 16'h0001;
         FS_ADD:      f_s = A + B;
         FS_ADD_INC:  f_s = A + B + 16'h0001;
         FS_ADD_NOTB: f_s = A + ~B;
         FS_SUB:      f_s = A + ~B + 16'h0001;
         FS_DEC:      f_s = A - 16'h0001;
         FS_PASS_A2:  f_s = A;
         FS_AND:      f_s = A & B;
         FS_OR:       f_s = A | B;
         FS_XOR:      f_s = A ^ B;
         FS_NOT_A:    f_s = ~A;
         FS_PASS_B:   f_s = B;
         FS_SHR:      f_s = {1'b0, B[WORD_W-1:1]};
         FS_SHL:      f_s = {B[WORD_W-2:0], 1'b0};
         FS_ZERO:     f_s = 16'h0000;
         default:     f_s = 16'h0000;
      endcase
   end

   assign F = f_s;
   assign Z = (f_s == 16'h0000);

endmodule

// File: rtl/data_path.sv
// Register file, unified 64-word memory and function unit of the processor data path.
// Reads are combinational; register and memory writes commit on the clock edge.
module data_path
   import data_path_pkg::*;
(
   input  logic        clk_main,
   input  logic        reset,
   data_path_if.slave  dp
);

   word_t             regs_r [NUM_REGS];
   // Memory is never cleared; its contents survive reset.
   word_t             mem_r  [MEM_DEPTH] = mem_image();

   word_t             a_s;
   word_t             b_s;
   word_t             f_s;
   word_t             d_s;
   word_t             mem_rd_s;
   logic [ADDR_W-1:0] addr_s;
   logic              z_s;

   // Read ports, operand/address muxes and write-back select
   always_comb begin
      a_s = regs_r[dp.SA];
      if (dp.MB) begin
         b_s = {12'h000, dp.SB};
      end else begin
         b_s = regs_r[dp.SB];
      end
      if (dp.MM) begin
         addr_s = dp.PC;
      end else begin
         addr_s = a_s[ADDR_W-1:0];
      end
      mem_rd_s = mem_r[addr_s];
      if (dp.MD) begin
         d_s = mem_rd_s;
      end else begin
         d_s = f_s;
      end
   end

   function_unit u_function_unit (
      .A  (a_s),
      .B  (b_s),
      .FS (dp.FS),
      .F  (f_s),
      .Z  (z_s)
   );

   // Register and memory write-back; reset holds off both writes
   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 16'h0000;
         end
      end else begin
         if (dp.RW) begin
            regs_r[dp.DR] <= d_s;
         end
         if (dp.MW && !dp.MM) begin
            mem_r[a_s[ADDR_W-1:0]] <= b_s;
         end
      end
   end

   assign dp.InstructIn = mem_rd_s;
   assign dp.BusA       = a_s[ADDR_W-1:0];
   assign dp.Z          = z_s;

endmodule
